// File: rtl/pattern_gen01.sv
// Bit-pattern generator: emits an 8-bit LFSR word corrected one bit per cycle to hit a requested popcount class.
// Optional seed-load ports are enabled by defining PATGEN_SEED_LOAD_EN.
module pattern_gen01 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_i,
  input  logic [1:0] req_class_i,
  output logic       req_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic [3:0] out_count_o,
  output logic       out_err_o,
`ifdef PATGEN_SEED_LOAD_EN
  input  logic       seed_load_i,
  input  logic [7:0] seed_i,
`endif
  input  logic       out_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIX  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [1:0] CLS_LESS  = 2'b00;
  localparam logic [1:0] CLS_MORE  = 2'b01;
  localparam logic [1:0] CLS_EQUAL = 2'b10;
  localparam logic [1:0] CLS_ILL   = 2'b11;

  state_e      state_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  cand_q;
  logic [1:0]  class_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        out_err_q;

  logic [7:0]  lfsr_d;
  logic [7:0]  cand_d;
  logic [3:0]  cand_pop;
  logic        cand_ok;
  logic        need_set;
  logic        accept;
  logic        seed_go;
  logic [7:0]  seed_val;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

`ifdef PATGEN_SEED_LOAD_EN
  // The all-zero state would lock the LFSR, so a zero seed is promoted to 1.
  assign seed_go  = (state_q == IDLE) && seed_load_i;
  assign seed_val = (seed_i == 8'h00) ? 8'h01 : seed_i;
`else
  assign seed_go  = 1'b0;
  assign seed_val = 8'h01;
`endif

  assign lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign req_ready_o = (state_q == IDLE) && !seed_go;
  assign accept      = req_valid_i && req_ready_o;

  assign cand_pop = popcnt8(cand_q);

  always_comb begin
    cand_ok = 1'b0;
    case (class_q)
      CLS_LESS:  cand_ok = (cand_pop <= 4'd3);
      CLS_MORE:  cand_ok = (cand_pop >= 4'd5);
      CLS_EQUAL: cand_ok = (cand_pop == 4'd4);
      default:   cand_ok = 1'b0;
    endcase
  end

  // x|(x+1) sets the lowest zero bit; x&(x-1) clears the lowest one bit.
  assign need_set = (class_q == CLS_MORE) || ((class_q == CLS_EQUAL) && (cand_pop < 4'd4));
  assign cand_d   = need_set ? (cand_q | (cand_q + 8'd1)) : (cand_q & (cand_q - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= 8'hA5;
      cand_q      <= 8'h00;
      class_q     <= CLS_LESS;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seed_go) begin
            lfsr_q <= seed_val;
          end else if (accept) begin
            if (req_class_i == CLS_ILL) begin
              out_data_q  <= 8'h00;
              out_err_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              cand_q  <= lfsr_q;
              lfsr_q  <= lfsr_d;
              class_q <= req_class_i;
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          if (cand_ok) begin
            out_data_q  <= cand_q;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            cand_q <= cand_d;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_err_o   = out_err_q;
  assign out_count_o = out_valid_q ? popcnt8(out_data_q) : 4'd0;

endmodule

// File: tb/tb_pattern_gen01.sv
// Directed bench for pattern_gen01 with hand-computed expected words and latencies.
// Seed-load cases run only when PATGEN_SEED_LOAD_EN is defined.
module tb_pattern_gen01;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_class;
  logic       req_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_count;
  logic       out_err;
  logic       out_ready;
`ifdef PATGEN_SEED_LOAD_EN
  logic       seed_load;
  logic [7:0] seed;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pattern_gen01 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_class_i (req_class),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_count_o (out_count),
    .out_err_o   (out_err),
`ifdef PATGEN_SEED_LOAD_EN
    .seed_load_i (seed_load),
    .seed_i      (seed),
`endif
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_data"},  out_data,  8'h00);
    chk({tag, "_count"}, out_count, 0);
    chk({tag, "_err"},   out_err,   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_class = 2'b00;
    out_ready = 1'b0;
`ifdef PATGEN_SEED_LOAD_EN
    seed_load = 1'b0;
    seed      = 8'h00;
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one request, measure latency, optionally stall the consumer, then complete the handshake.
  task automatic do_req(input string tag, input logic [1:0] cls, input logic [7:0] e_data,
                        input logic [3:0] e_cnt, input logic e_err, input int e_lat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, "_ready_before"}, req_ready, 1);
    req_valid = 1'b1;
    req_class = cls;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_class = ~cls;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_data"},    out_data,  e_data);
    chk({tag, "_count"},   out_count, e_cnt);
    chk({tag, "_err"},     out_err,   e_err);
    chk({tag, "_ready_busy"}, req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_data"},  out_data,  e_data);
      chk({tag, "_hold_count"}, out_count, e_cnt);
      chk({tag, "_hold_ready"}, req_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_err"},   out_err,   0);
    chk({tag, "_done_count"}, out_count, 0);
    chk({tag, "_done_ready"}, req_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_class = 2'b00;
    out_ready = 1'b0;
`ifdef PATGEN_SEED_LOAD_EN
    seed_load = 1'b0;
    seed      = 8'h00;
`endif
    #1;
    chk_reset_outputs("por");

    // Equal class on the reset word A5 (popcount 4) needs no flips.
    do_reset();
    chk_reset_outputs("after_reset");
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_out_ready_no_effect", out_valid, 0);
    out_ready = 1'b0;
    do_req("eq_a5", 2'b10, 8'hA5, 4'd4, 1'b0, 2, 0);

    // More-ones on A5 sets bit1; class change after accept must be ignored.
    do_reset();
    do_req("more_a5", 2'b01, 8'hA7, 4'd5, 1'b0, 3, 0);

    // Second word 4A: more-ones sets bit0 then bit2.
    do_reset();
    do_req("eq_first", 2'b10, 8'hA5, 4'd4, 1'b0, 2, 0);
    do_req("more_4a",  2'b01, 8'h4F, 4'd5, 1'b0, 4, 0);

    // Less-ones on 4A already satisfied; consumer stalls for 5 cycles.
    do_reset();
    do_req("eq_first2", 2'b10, 8'hA5, 4'd4, 1'b0, 2, 0);
    do_req("less_4a",   2'b00, 8'h4A, 4'd3, 1'b0, 2, 5);

    // Illegal class does not advance the LFSR.
    do_reset();
    do_req("illegal",   2'b11, 8'h00, 4'd0, 1'b1, 1, 2);
    do_req("eq_after_ill", 2'b10, 8'hA5, 4'd4, 1'b0, 2, 0);

    // Reset mid-FIX discards the request and restores the LFSR.
    do_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_class = 2'b01;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midfix_busy", req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midfix_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midfix_no_result", out_valid, 0);
    do_req("eq_after_midfix", 2'b10, 8'hA5, 4'd4, 1'b0, 2, 0);

    // Reset mid-OUT clears the held illegal result at once.
    do_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_class = 2'b11;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midout_valid_before", out_valid, 1);
    chk("midout_err_before",   out_err,   1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midout_rst");

`ifdef PATGEN_SEED_LOAD_EN
    // Zero seed loads as 01; seed_load blocks a simultaneous request.
    do_reset();
    @(negedge clk);
    seed_load = 1'b1;
    seed      = 8'h00;
    req_valid = 1'b1;
    req_class = 2'b10;
    #1;
    chk("seed_blocks_ready", req_ready, 0);
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("seed_no_accept", req_ready, 1);
    do_req("seed_more", 2'b01, 8'h1F, 4'd5, 1'b0, 6, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pattern_gen01.md
# pattern_gen01

Bit-pattern generator, the producing end of the zero/one majority-classification interface. It accepts a requested class over a valid/ready handshake: more zeros, more ones, or equal. It then emits an 8-bit word whose popcount satisfies that class. Words come from an internal LFSR and are corrected one bit per cycle. It sits upstream of the byte majority classifier as a stimulus and traffic source.

## Interface
- No parameters; widths fixed at 8-bit data and 2-bit class.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_class  in  2  requested class:
  - 00: ones < zeros
  - 01: ones > zeros
  - 10: equal
  - 11: illegal
- req_ready  out  1  block can accept a request
- out_valid  out  1  result word present
- out_data  out  8  generated word
- out_count  out  4  popcount of out_data
- out_err  out  1  result belongs to an illegal request
- out_ready  in  1  consumer accepts result

## Operation
- States:
  - IDLE: req_ready=1.
  - FIX: correct the candidate.
  - OUT: out_valid=1.
- LFSR: 8-bit Fibonacci, shifts left.
  - feedback = b7^b5^b4^b3, inserted at b0.
  - Reset value 8'hA5.
  - Never holds 0.
- Request accept (IDLE, req_valid & req_ready) with legal class:
  - candidate <= lfsr.
  - lfsr advances one step.
  - class is latched.
  - state <= FIX.
- Request accept with class 11:
  - out_data <= 8'h00 and out_err <= 1.
  - lfsr does not advance.
  - state <= OUT.
- FIX cycle, with p = popcount(candidate), 0..8, 4-bit:
  - Satisfied when: class 00 → p≤3; class 01 → p≥5; class 10 → p==4.
  - If satisfied: state <= OUT; out_data = candidate.
  - Else, class 01, or class 10 with p<4: set the lowest-index 0 bit.
  - Else, class 00, or class 10 with p>4: clear the lowest-index 1 bit.
  - Exactly one bit flips per FIX cycle.
- OUT:
  - out_data, out_count and out_err are held stable while out_ready=0.
  - On out_valid & out_ready: state <= IDLE; out_err clears.
- Requests are never pipelined: one outstanding request at a time.

## Timing
- Reset (async assert, any state):
  - state=IDLE, lfsr=8'hA5, req_ready=1.
  - out_valid=0, out_data=8'h00, out_count=0, out_err=0.
  - Reset mid-FIX or mid-OUT discards the request; no result is emitted.
- Latency, counted from the accepting edge to the first edge at which out_valid is observed high:
  - 2+k cycles for a legal class, where k = flips needed; k≤5, so max 7.
  - 1 cycle for class 11.
- req_ready goes low the cycle after acceptance. It returns high the cycle after the output handshake, so minimum request spacing is 3 cycles.
- req_class is sampled only at the accepting edge; later changes are ignored.
- out_count is combinational from the out_data register. It is 0 when out_valid=0.
- out_ready while out_valid=0 has no effect.

## Configuration
- PATGEN_SEED_LOAD_EN:
  - When defined, adds ports seed_load (in, 1) and seed (in, 8).
  - In IDLE, seed_load=1 loads lfsr <= seed; seed 8'h00 loads as 8'h01.
  - seed_load forces req_ready=0 that cycle, so seed takes priority over a request.
  - Outside IDLE, seed_load is ignored.
- When not defined, the ports are absent and the LFSR is set only by reset.

## Test plan
- Reset, req class 10, out_ready=1 → out_valid after 2 cycles, out_data=8'hA5, out_count=4, out_err=0.
- Reset, req class 01 → one flip, bit1; out_data=8'hA7, out_count=5, latency 3.
- Reset, request class 10 (consumes A5), then class 01 → candidate 8'h4A; flips bit0 then bit2; out_data=8'h4F, count 5, latency 4.
- Reset, request class 10, then class 00 → out_data=8'h4A, count 3, latency 2. Hold out_ready=0 for 5 cycles → data, count and valid stable; req_ready stays 0.
- Class 11 request → out_valid after 1 cycle, out_data=8'h00, out_err=1. A following class 10 request still yields 8'hA5.
- With PATGEN_SEED_LOAD_EN: seed_load with seed=8'h00, then class 01 → candidate 8'h01; flips bits 1,2,3,4; out_data=8'h1F, latency 6. Assert rst_n=0 mid-FIX → all outputs return to reset values immediately.
